// File: rtl/datamem_arbiter_if.sv
// Bus bundle between the CPU execute stage, the external requester and datamem.
// The slave modport is the arbiter's view; the master modport is the surrounding system's.
interface datamem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_rd_en;
  logic          cpu_wr_en;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt;
  logic [DW-1:0] ext_rdata;
  logic          ext_rvalid;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;

  modport slave (
    input  cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, ext_gnt, ext_rdata, ext_rvalid,
    output mem_addr, mem_re, mem_we, mem_wdata, owner
  );

  modport master (
    output cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, ext_gnt, ext_rdata, ext_rvalid,
    input  mem_addr, mem_re, mem_we, mem_wdata, owner
  );
endinterface

// File: rtl/datamem_arbiter.sv
// Data-memory arbiter: CPU priority, external requester forced in after MAX_WAIT lost cycles.
// Optional DATAMEM_ARB_STATS_EN adds saturating grant/stall counters.
module datamem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AW       = 16,
  parameter int DW       = 16
) (
  input  logic               clk,
  input  logic               reset,
  datamem_arbiter_if.slave   bus
`ifdef DATAMEM_ARB_STATS_EN
  ,
  output logic [15:0]        cpu_gnt_cnt,
  output logic [15:0]        ext_gnt_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  owner_e        dec_d;
  owner_e        owner_q;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          ext_rvalid_q;
  logic [DW-1:0] ext_rdata_q;
  logic          cpu_acc;
  logic          force_ext;

  assign cpu_acc   = bus.cpu_rd_en | bus.cpu_wr_en;
  assign force_ext = (wait_cnt_q == WAIT_MAX) & bus.ext_req;

  always_comb begin
    dec_d = OWN_IDLE;
    if (force_ext)        dec_d = OWN_EXT;
    else if (cpu_acc)     dec_d = OWN_CPU;
    else if (bus.ext_req) dec_d = OWN_EXT;
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    unique case (dec_d)
      OWN_CPU: begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_re    = bus.cpu_rd_en;
        bus.mem_we    = bus.cpu_wr_en;
      end
      OWN_EXT: begin
        bus.mem_addr  = bus.ext_addr;
        bus.mem_wdata = bus.ext_wdata;
        bus.mem_re    = ~bus.ext_we;
        bus.mem_we    = bus.ext_we;
      end
      default: ;
    endcase
  end

  assign bus.ext_gnt    = (dec_d == OWN_EXT);
  assign bus.cpu_stall  = (dec_d == OWN_EXT) & cpu_acc;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.ext_rdata  = ext_rdata_q;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.owner      = owner_q;

  // Counter only advances while the request is actively losing; a grant or a withdrawn request restarts it.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.ext_req || bus.ext_gnt) wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= OWN_IDLE;
      wait_cnt_q   <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      owner_q      <= dec_d;
      wait_cnt_q   <= wait_cnt_d;
      ext_rvalid_q <= bus.ext_gnt & ~bus.ext_we;
      if (bus.ext_gnt && !bus.ext_we) ext_rdata_q <= bus.mem_rdata;
    end
  end

`ifdef DATAMEM_ARB_STATS_EN
  logic [15:0] cpu_gnt_cnt_q, ext_gnt_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_gnt_cnt_q <= '0;
      ext_gnt_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if ((dec_d == OWN_CPU) && (cpu_gnt_cnt_q != '1)) cpu_gnt_cnt_q <= cpu_gnt_cnt_q + 16'd1;
      if (bus.ext_gnt && (ext_gnt_cnt_q != '1))        ext_gnt_cnt_q <= ext_gnt_cnt_q + 16'd1;
      if (bus.cpu_stall && (stall_cnt_q != '1))        stall_cnt_q   <= stall_cnt_q + 16'd1;
    end
  end

  assign cpu_gnt_cnt = cpu_gnt_cnt_q;
  assign ext_gnt_cnt = ext_gnt_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter: vector table plus contention/reset/withdraw sequences.
// Stats counters are exercised only when DATAMEM_ARB_STATS_EN is defined.
module tb_datamem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  datamem_arbiter_if #(.AW(16), .DW(16)) bus ();

`ifdef DATAMEM_ARB_STATS_EN
  logic [15:0] cpu_gnt_cnt, ext_gnt_cnt, stall_cnt;
`endif

  datamem_arbiter #(.MAX_WAIT(4), .AW(16), .DW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DATAMEM_ARB_STATS_EN
    ,
    .cpu_gnt_cnt (cpu_gnt_cnt),
    .ext_gnt_cnt (ext_gnt_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  logic [15:0] mem [0:65535];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  int unsigned total = 0;
  int unsigned passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic crd, input logic cwr, input logic [15:0] caddr, input logic [15:0] cwd,
                       input logic er, input logic ewe, input logic [15:0] eaddr, input logic [15:0] ewd);
    bus.cpu_rd_en = crd;
    bus.cpu_wr_en = cwr;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.ext_req   = er;
    bus.ext_we    = ewe;
    bus.ext_addr  = eaddr;
    bus.ext_wdata = ewd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        crd, cwr;
    logic [15:0] caddr, cwd;
    logic        er, ewe;
    logic [15:0] eaddr, ewd;
    logic        xre, xwe;
    logic [15:0] xaddr, xwd, xcrd;
    logic        xstall, xgnt;
    logic [1:0]  xown;
    logic        xrv;
    logic [15:0] xerd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0020] = 16'h1234;

    //          crd cwr caddr    cwd      er ewe eaddr    ewd      re we addr     wd       cpu_rd   st gn own rv erd
    vecs[0]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 16'h0000};
    vecs[1]  = '{1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 0, 2'd1, 0, 16'h0000};
    vecs[2]  = '{0, 1, 16'h0030, 16'h5555, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0030, 16'h5555, 16'h0000, 0, 0, 2'd1, 0, 16'h0000};
    vecs[3]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0020, 16'h0000, 16'h1234, 0, 1, 2'd2, 1, 16'h1234};
    vecs[4]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0040, 16'hA5A5, 0, 1, 16'h0040, 16'hA5A5, 16'h0000, 0, 1, 2'd2, 0, 16'h1234};
    vecs[5]  = '{1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0030, 16'h0000, 16'h5555, 0, 0, 2'd1, 0, 16'h1234};
    vecs[6]  = '{1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0040, 16'h0000, 16'hA5A5, 0, 0, 2'd1, 0, 16'h1234};
    vecs[7]  = '{0, 1, 16'h0060, 16'h0F0F, 1, 0, 16'h0010, 16'h0000, 0, 1, 16'h0060, 16'h0F0F, 16'h0000, 0, 0, 2'd1, 0, 16'h1234};
    vecs[8]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 1, 2'd2, 1, 16'hBEEF};
    vecs[9]  = '{1, 0, 16'h0060, 16'h0000, 1, 1, 16'h0070, 16'h9999, 1, 0, 16'h0060, 16'h0000, 16'h0F0F, 0, 0, 2'd1, 0, 16'hBEEF};
    vecs[10] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 16'hBEEF};

    do_reset();
    chk("rst_owner",  32'(bus.owner), 32'd0);
    chk("rst_rvalid", 32'(bus.ext_rvalid), 32'd0);
    chk("rst_rdata",  32'(bus.ext_rdata), 32'd0);
    chk("rst_wait",   32'(dut.wait_cnt_q), 32'd0);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].crd, vecs[i].cwr, vecs[i].caddr, vecs[i].cwd,
            vecs[i].er, vecs[i].ewe, vecs[i].eaddr, vecs[i].ewd);
      #1;
      chk($sformatf("v%0d_mem_re", i),    32'(bus.mem_re),    32'(vecs[i].xre));
      chk($sformatf("v%0d_mem_we", i),    32'(bus.mem_we),    32'(vecs[i].xwe));
      chk($sformatf("v%0d_mem_addr", i),  32'(bus.mem_addr),  32'(vecs[i].xaddr));
      chk($sformatf("v%0d_mem_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].xwd));
      chk($sformatf("v%0d_cpu_rdata", i), 32'(bus.cpu_rdata), 32'(vecs[i].xcrd));
      chk($sformatf("v%0d_cpu_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].xstall));
      chk($sformatf("v%0d_ext_gnt", i),   32'(bus.ext_gnt),   32'(vecs[i].xgnt));
      step();
      chk($sformatf("v%0d_owner", i),     32'(bus.owner),      32'(vecs[i].xown));
      chk($sformatf("v%0d_rvalid", i),    32'(bus.ext_rvalid), 32'(vecs[i].xrv));
      chk($sformatf("v%0d_ext_rdata", i), 32'(bus.ext_rdata),  32'(vecs[i].xerd));
    end
    chk("ext_write_landed", 32'(mem[16'h0040]), 32'hA5A5);

    // Read grant in flight when reset hits: grant is still combinational, rvalid must be discarded.
    drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0);
    reset = 1'b1;
    #1;
    chk("rstflight_gnt", 32'(bus.ext_gnt), 32'd1);
    step();
    reset = 1'b0;
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("rstflight_rvalid", 32'(bus.ext_rvalid), 32'd0);
    chk("rstflight_owner",  32'(bus.owner), 32'd0);
    chk("rstflight_wait",   32'(dut.wait_cnt_q), 32'd0);
    chk("rstflight_rdata",  32'(bus.ext_rdata), 32'd0);
    step();
    chk("rstflight_rvalid2", 32'(bus.ext_rvalid), 32'd0);

    // Contention: CPU reads every cycle, ext write held for ten cycles.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      drive(1, 0, 16'h0010, 16'h0, 1, 1, 16'h0050, 16'h7777);
      #1;
      chk($sformatf("cont%0d_wait", k),  32'(dut.wait_cnt_q), (k <= 5) ? 32'(k - 1) : 32'(k - 6));
      chk($sformatf("cont%0d_gnt", k),   32'(bus.ext_gnt),    (k == 5 || k == 10) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_stall", k), 32'(bus.cpu_stall),  (k == 5 || k == 10) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_we", k),    32'(bus.mem_we),     (k == 5 || k == 10) ? 32'd1 : 32'd0);
      step();
      chk($sformatf("cont%0d_owner", k), 32'(bus.owner),      (k == 5 || k == 10) ? 32'd2 : 32'd1);
    end
    chk("cont_wait_after", 32'(dut.wait_cnt_q), 32'd0);
    chk("cont_mem", 32'(mem[16'h0050]), 32'h7777);

    // Request withdrawn before grant, then a fresh request waits the full window again.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive(1, 0, 16'h0010, 16'h0, (k <= 2) ? 1'b1 : 1'b0, 1, 16'h0080, 16'h1111);
      #1;
      chk($sformatf("drop%0d_gnt", k), 32'(bus.ext_gnt), 32'd0);
      chk($sformatf("drop%0d_we", k),  32'(bus.mem_we),  32'd0);
      step();
    end
    chk("drop_wait", 32'(dut.wait_cnt_q), 32'd0);
    chk("drop_mem",  32'(mem[16'h0080]), 32'h0000);
    for (int k = 1; k <= 5; k++) begin
      drive(1, 0, 16'h0010, 16'h0, 1, 1, 16'h0080, 16'h1111);
      #1;
      chk($sformatf("rereq%0d_gnt", k), 32'(bus.ext_gnt), (k == 5) ? 32'd1 : 32'd0);
      step();
    end
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("rereq_mem", 32'(mem[16'h0080]), 32'h1111);

`ifdef DATAMEM_ARB_STATS_EN
    do_reset();
    chk("st_rst_cpu", 32'(cpu_gnt_cnt), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
      step();
    end
    for (int k = 1; k <= 5; k++) begin
      drive(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0);
      step();
    end
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    step();
    chk("st_cpu",   32'(cpu_gnt_cnt), 32'd7);
    chk("st_ext",   32'(ext_gnt_cnt), 32'd1);
    chk("st_stall", 32'(stall_cnt),   32'd1);
    drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    for (int k = 0; k < 65535; k++) @(posedge clk);
    #1;
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("st_cpu_sat", 32'(cpu_gnt_cnt), 32'hFFFF);
    chk("st_ext_hold", 32'(ext_gnt_cnt), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
